// File: rtl/photon_pkg.sv
// Shared fixed-point constants and types for the photon boundary-interaction stage.
package photon_pkg;

    localparam int LAYER_W           = 3;
    localparam int PHOTON_NUM_LAYERS = 5;

    localparam logic [63:0] ONE_Q2_62 = 64'h4000_0000_0000_0000;
    localparam logic [31:0] ONE_Q1_31 = 32'h7FFF_FFFF;

    typedef struct packed {
        logic [31:0] ux;
        logic [31:0] uy;
        logic [31:0] uz;
    } photon_dir_t;

    // Q1.31 negate; -1.0 has no positive twin, so it maps to the largest positive value.
    function automatic logic [31:0] neg_sat(input logic [31:0] v);
        return (v == 32'h8000_0000) ? ONE_Q1_31 : (~v + 32'd1);
    endfunction

endpackage

// File: rtl/photon_reflector_if.sv
// Photon in/out bus of the boundary-interaction stage.
interface photon_reflector_if;
    import photon_pkg::*;

    // i_valid marks a photon on the input this enabled clock; o_valid marks a result.
    // There is no ready: the consumer must take every o_valid on the enabled clock it appears.
    logic               i_valid;
    logic               i_hit;
    logic               i_dead;
    logic [LAYER_W-1:0] i_layer;
    logic [31:0]        i_ux;
    logic [31:0]        i_uy;
    logic [31:0]        i_uz;
    logic [31:0]        i_rand;
    logic [63:0]        i_uz_2;
    logic [31:0]        i_uz2;
    logic [63:0]        i_sa2_2;
    logic [63:0]        i_uz2_2;
    logic [31:0]        i_ux_transmitted;
    logic [31:0]        i_uy_transmitted;

    logic               o_valid;
    logic               o_dead;
    logic               o_reflected;
    logic               o_escaped;
    logic [LAYER_W-1:0] o_layer;
    logic [31:0]        o_ux;
    logic [31:0]        o_uy;
    logic [31:0]        o_uz;

    modport master (
        output i_valid, i_hit, i_dead, i_layer, i_ux, i_uy, i_uz, i_rand,
               i_uz_2, i_uz2, i_sa2_2, i_uz2_2, i_ux_transmitted, i_uy_transmitted,
        input  o_valid, o_dead, o_reflected, o_escaped, o_layer, o_ux, o_uy, o_uz
    );

    modport slave (
        input  i_valid, i_hit, i_dead, i_layer, i_ux, i_uy, i_uz, i_rand,
               i_uz_2, i_uz2, i_sa2_2, i_uz2_2, i_ux_transmitted, i_uy_transmitted,
        output o_valid, o_dead, o_reflected, o_escaped, o_layer, o_ux, o_uy, o_uz
    );

endinterface

// File: rtl/photon_reflector_fresnel_compare.sv
// Three-stage Fresnel reflectance test: reflect = TIR or (rand * D) >> 32 < N.
module fresnel_compare
    import photon_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] uz,
    input  logic [31:0] uz2,
    input  logic [31:0] rand_u,
    input  logic [63:0] uz_2,
    input  logic [63:0] uz2_2,
    input  logic [63:0] sa2_2,
    output logic        reflect
);

    typedef struct packed {
        logic        tir;
        logic [31:0] rnd;
        logic [63:0] p;
        logic [63:0] uz_2;
        logic [63:0] uz2_2;
    } s1_t;

    typedef struct packed {
        logic        tir;
        logic [31:0] rnd;
        logic [65:0] num;
        logic [65:0] den;
    } s2_t;

    typedef struct packed {
        logic        tir;
        logic [65:0] num;
        logic [97:0] prod;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic [31:0] abs_uz;
    logic [65:0] sum2;
    logic [65:0] two_p;

    always_comb begin
        s1_d   = s1_q;
        s2_d   = s2_q;
        s3_d   = s3_q;
        abs_uz = uz[31] ? (~uz + 32'd1) : uz;
        sum2   = {2'b00, s1_q.uz_2} + {2'b00, s1_q.uz2_2};
        two_p  = {1'b0, s1_q.p, 1'b0};
        if (enable) begin
            s1_d.tir   = (sa2_2 >= ONE_Q2_62) || (uz2 == 32'd0);
            s1_d.rnd   = rand_u;
            s1_d.p     = {32'd0, abs_uz} * {32'd0, uz2};
            s1_d.uz_2  = uz_2;
            s1_d.uz2_2 = uz2_2;

            s2_d.tir = s1_q.tir;
            s2_d.rnd = s1_q.rnd;
            s2_d.num = sum2 - two_p;
            s2_d.den = sum2 + two_p;

            // Full 98-bit product so the compare sees every bit of rand * D.
            s3_d.tir  = s2_q.tir;
            s3_d.num  = s2_q.num;
            s3_d.prod = {66'd0, s2_q.rnd} * {32'd0, s2_q.den};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign reflect = s3_q.tir || (s3_q.prod[97:32] < s3_q.num);

endmodule

// File: rtl/photon_reflector.sv
// Boundary-interaction stage: chooses reflect / transmit / escape for each photon, 4-clock latency.
module photon_reflector
    import photon_pkg::*;
#(
    parameter int NUM_LAYERS = PHOTON_NUM_LAYERS
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    photon_reflector_if.slave  pif
);

    typedef struct packed {
        logic               valid;
        logic               hit;
        logic               dead;
        logic [LAYER_W-1:0] layer;
        photon_dir_t        dir;
        logic [31:0]        uz2;
        logic [31:0]        ux_t;
        logic [31:0]        uy_t;
    } side_t;

    typedef struct packed {
        logic               valid;
        logic               dead;
        logic               reflected;
        logic               escaped;
        logic [LAYER_W-1:0] layer;
        photon_dir_t        dir;
    } out_t;

    localparam out_t OUT_RST = '{valid: 1'b0, dead: 1'b0, reflected: 1'b0, escaped: 1'b0,
                                 layer: '0, dir: '{ux: 32'd0, uy: 32'd0, uz: ONE_Q1_31}};

    side_t in_side;
    side_t s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    out_t  out_d, out_q;

    logic        reflect;
    logic        down;
    logic        escape;
    logic [31:0] t_uz;

    fresnel_compare u_fresnel (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .uz     (pif.i_uz),
        .uz2    (pif.i_uz2),
        .rand_u (pif.i_rand),
        .uz_2   (pif.i_uz_2),
        .uz2_2  (pif.i_uz2_2),
        .sa2_2  (pif.i_sa2_2),
        .reflect(reflect)
    );

    always_comb begin
        in_side.valid  = pif.i_valid;
        in_side.hit    = pif.i_hit;
        in_side.dead   = pif.i_dead;
        in_side.layer  = pif.i_layer;
        in_side.dir.ux = pif.i_ux;
        in_side.dir.uy = pif.i_uy;
        in_side.dir.uz = pif.i_uz;
        in_side.uz2    = pif.i_uz2;
        in_side.ux_t   = pif.i_ux_transmitted;
        in_side.uy_t   = pif.i_uy_transmitted;

        s1_d = enable ? in_side : s1_q;
        s2_d = enable ? s1_q    : s2_q;
        s3_d = enable ? s2_q    : s3_q;

        down   = s3_q.dir.uz[31];
        t_uz   = down ? neg_sat(s3_q.uz2) : s3_q.uz2;
        escape = down ? (s3_q.layer == LAYER_W'(1)) : (s3_q.layer == LAYER_W'(NUM_LAYERS));

        out_d = out_q;
        if (enable) begin
            out_d.valid     = s3_q.valid;
            out_d.dead      = s3_q.dead;
            out_d.layer     = s3_q.layer;
            out_d.dir       = s3_q.dir;
            out_d.reflected = 1'b0;
            out_d.escaped   = 1'b0;
            if (s3_q.hit && !s3_q.dead) begin
                if (reflect) begin
                    out_d.dir.uz    = neg_sat(s3_q.dir.uz);
                    out_d.reflected = 1'b1;
                end else begin
                    out_d.dir.ux = s3_q.ux_t;
                    out_d.dir.uy = s3_q.uy_t;
                    out_d.dir.uz = t_uz;
                    // Leaving the outermost layer kills the photon but keeps its layer index.
                    if (escape) begin
                        out_d.dead    = 1'b1;
                        out_d.escaped = 1'b1;
                    end else begin
                        out_d.layer = down ? (s3_q.layer - LAYER_W'(1)) : (s3_q.layer + LAYER_W'(1));
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            out_q <= OUT_RST;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            out_q <= out_d;
        end
    end

    assign pif.o_valid     = out_q.valid;
    assign pif.o_dead      = out_q.dead;
    assign pif.o_reflected = out_q.reflected;
    assign pif.o_escaped   = out_q.escaped;
    assign pif.o_layer     = out_q.layer;
    assign pif.o_ux        = out_q.dir.ux;
    assign pif.o_uy        = out_q.dir.uy;
    assign pif.o_uz        = out_q.dir.uz;

endmodule

// File: tb/tb_photon_reflector.sv
// Directed bench for photon_reflector: reset, Fresnel/TIR/escape decisions, stall and flush.
module tb_photon_reflector;
    import photon_pkg::*;

    localparam logic [31:0] A    = 32'h7FFF_FFFF;
    localparam logic [63:0] A2   = 64'h3FFF_FFFF_0000_0001;
    localparam logic [63:0] B2   = 64'h1000_0000_0000_0000;
    localparam logic [63:0] H2   = 64'h0900_0000_0000_0000;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    photon_reflector_if pif ();

    photon_reflector dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .pif   (pif)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic hit, input logic dead, input logic [2:0] layer,
                         input logic [31:0] ux, input logic [31:0] uy, input logic [31:0] uz,
                         input logic [31:0] uz2, input logic [31:0] rnd,
                         input logic [63:0] uz_2, input logic [63:0] uz2_2, input logic [63:0] sa2_2,
                         input logic [31:0] uxt, input logic [31:0] uyt);
        pif.i_valid          = 1'b1;
        pif.i_hit            = hit;
        pif.i_dead           = dead;
        pif.i_layer          = layer;
        pif.i_ux             = ux;
        pif.i_uy             = uy;
        pif.i_uz             = uz;
        pif.i_uz2            = uz2;
        pif.i_rand           = rnd;
        pif.i_uz_2           = uz_2;
        pif.i_uz2_2          = uz2_2;
        pif.i_sa2_2          = sa2_2;
        pif.i_ux_transmitted = uxt;
        pif.i_uy_transmitted = uyt;
    endtask

    task automatic launch(input logic hit, input logic dead, input logic [2:0] layer,
                          input logic [31:0] ux, input logic [31:0] uy, input logic [31:0] uz,
                          input logic [31:0] uz2, input logic [31:0] rnd,
                          input logic [63:0] uz_2, input logic [63:0] uz2_2, input logic [63:0] sa2_2,
                          input logic [31:0] uxt, input logic [31:0] uyt);
        drive(hit, dead, layer, ux, uy, uz, uz2, rnd, uz_2, uz2_2, sa2_2, uxt, uyt);
        step;
        pif.i_valid = 1'b0;
        repeat (3) step;
    endtask

    task automatic test_reset;
        enable = 1'b1;
        reset  = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 32'h0100_0000, 32'h0200_0000, A, A, 32'd0, A2, A2, 64'd0, 32'h0555_0000, 32'h0666_0000);
        repeat (2) step;
        total++; if (pif.o_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", pif.o_valid); else passed++;
        total++; if (pif.o_dead !== 1'b0) $display("FAIL rst_dead: got %b exp 0", pif.o_dead); else passed++;
        total++; if (pif.o_reflected !== 1'b0) $display("FAIL rst_refl: got %b exp 0", pif.o_reflected); else passed++;
        total++; if (pif.o_escaped !== 1'b0) $display("FAIL rst_esc: got %b exp 0", pif.o_escaped); else passed++;
        total++; if (pif.o_layer !== 3'd0) $display("FAIL rst_layer: got %h exp 0", pif.o_layer); else passed++;
        total++; if (pif.o_ux !== 32'd0) $display("FAIL rst_ux: got %h exp 0", pif.o_ux); else passed++;
        total++; if (pif.o_uy !== 32'd0) $display("FAIL rst_uy: got %h exp 0", pif.o_uy); else passed++;
        total++; if (pif.o_uz !== 32'h7FFF_FFFF) $display("FAIL rst_uz: got %h exp 7fffffff", pif.o_uz); else passed++;
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step;
            total++; if (pif.o_valid !== 1'b0) $display("FAIL rst_latency_%0d: got %b exp 0", k, pif.o_valid); else passed++;
        end
        step;
        total++; if (pif.o_valid !== 1'b1) $display("FAIL rst_first_out: got %b exp 1", pif.o_valid); else passed++;
        pif.i_valid = 1'b0;
        repeat (4) step;
        total++; if (pif.o_valid !== 1'b0) $display("FAIL rst_drain: got %b exp 0", pif.o_valid); else passed++;
    endtask

    task automatic test_matched;
        launch(1'b1, 1'b0, 3'd2, 32'h0100_0000, 32'h0200_0000, A, A, 32'd0, A2, A2, 64'd0, 32'h0555_0000, 32'h0666_0000);
        total++; if (pif.o_valid !== 1'b1) $display("FAIL match_valid: got %b exp 1", pif.o_valid); else passed++;
        total++; if (pif.o_layer !== 3'd3) $display("FAIL match_layer: got %h exp 3", pif.o_layer); else passed++;
        total++; if (pif.o_uz !== 32'h7FFF_FFFF) $display("FAIL match_uz: got %h exp 7fffffff", pif.o_uz); else passed++;
        total++; if (pif.o_reflected !== 1'b0) $display("FAIL match_refl: got %b exp 0", pif.o_reflected); else passed++;
        total++; if (pif.o_ux !== 32'h0555_0000) $display("FAIL match_ux: got %h exp 05550000", pif.o_ux); else passed++;
        total++; if (pif.o_uy !== 32'h0666_0000) $display("FAIL match_uy: got %h exp 06660000", pif.o_uy); else passed++;
        total++; if (pif.o_dead !== 1'b0) $display("FAIL match_dead: got %b exp 0", pif.o_dead); else passed++;
        step;
        total++; if (pif.o_valid !== 1'b0) $display("FAIL match_single: got %b exp 0", pif.o_valid); else passed++;
    endtask

    task automatic test_fresnel;
        launch(1'b1, 1'b0, 3'd2, 32'h0100_0000, 32'h0200_0000, A, 32'h4000_0000, 32'h1C00_0000, A2, B2, 64'd0, 32'h0555_0000, 32'h0666_0000);
        total++; if (pif.o_reflected !== 1'b1) $display("FAIL fres_lo_refl: got %b exp 1", pif.o_reflected); else passed++;
        total++; if (pif.o_uz !== 32'h8000_0001) $display("FAIL fres_lo_uz: got %h exp 80000001", pif.o_uz); else passed++;
        total++; if (pif.o_ux !== 32'h0100_0000) $display("FAIL fres_lo_ux: got %h exp 01000000", pif.o_ux); else passed++;
        total++; if (pif.o_layer !== 3'd2) $display("FAIL fres_lo_layer: got %h exp 2", pif.o_layer); else passed++;
        launch(1'b1, 1'b0, 3'd2, 32'h0100_0000, 32'h0200_0000, A, 32'h4000_0000, 32'h1D00_0000, A2, B2, 64'd0, 32'h0555_0000, 32'h0666_0000);
        total++; if (pif.o_reflected !== 1'b0) $display("FAIL fres_hi_refl: got %b exp 0", pif.o_reflected); else passed++;
        total++; if (pif.o_uz !== 32'h4000_0000) $display("FAIL fres_hi_uz: got %h exp 40000000", pif.o_uz); else passed++;
        total++; if (pif.o_layer !== 3'd3) $display("FAIL fres_hi_layer: got %h exp 3", pif.o_layer); else passed++;
    endtask

    task automatic test_tir;
        launch(1'b1, 1'b0, 3'd3, 32'h1000_0000, 32'h0ABC_0000, 32'hC000_0000, 32'h2000_0000, 32'hFFFF_FFFF,
               64'h1000_0000_0000_0000, 64'h0400_0000_0000_0000, 64'h4000_0000_0000_0001, 32'h0555_0000, 32'h0666_0000);
        total++; if (pif.o_reflected !== 1'b1) $display("FAIL tir_refl: got %b exp 1", pif.o_reflected); else passed++;
        total++; if (pif.o_uz !== 32'h4000_0000) $display("FAIL tir_uz: got %h exp 40000000", pif.o_uz); else passed++;
        total++; if (pif.o_ux !== 32'h1000_0000) $display("FAIL tir_ux: got %h exp 10000000", pif.o_ux); else passed++;
        total++; if (pif.o_layer !== 3'd3) $display("FAIL tir_layer: got %h exp 3", pif.o_layer); else passed++;
        launch(1'b1, 1'b0, 3'd4, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF,
               64'h4000_0000_0000_0000, 64'd0, 64'd0, 32'h0555_0000, 32'h0666_0000);
        total++; if (pif.o_reflected !== 1'b1) $display("FAIL tir0_refl: got %b exp 1", pif.o_reflected); else passed++;
        total++; if (pif.o_uz !== 32'h7FFF_FFFF) $display("FAIL tir0_uz_sat: got %h exp 7fffffff", pif.o_uz); else passed++;
    endtask

    task automatic test_escape;
        launch(1'b1, 1'b0, 3'd1, 32'h0100_0000, 32'h0200_0000, 32'hC000_0000, 32'h3000_0000, 32'hFFFF_FFFF,
               B2, H2, 64'd0, 32'h0777_0000, 32'h0888_0000);
        total++; if (pif.o_dead !== 1'b1) $display("FAIL esc_lo_dead: got %b exp 1", pif.o_dead); else passed++;
        total++; if (pif.o_escaped !== 1'b1) $display("FAIL esc_lo_esc: got %b exp 1", pif.o_escaped); else passed++;
        total++; if (pif.o_layer !== 3'd1) $display("FAIL esc_lo_layer: got %h exp 1", pif.o_layer); else passed++;
        total++; if (pif.o_uz !== 32'hD000_0000) $display("FAIL esc_lo_uz: got %h exp d0000000", pif.o_uz); else passed++;
        total++; if (pif.o_ux !== 32'h0777_0000) $display("FAIL esc_lo_ux: got %h exp 07770000", pif.o_ux); else passed++;
        launch(1'b1, 1'b0, 3'd5, 32'h0100_0000, 32'h0200_0000, 32'h4000_0000, 32'h3000_0000, 32'hFFFF_FFFF,
               B2, H2, 64'd0, 32'h0777_0000, 32'h0888_0000);
        total++; if (pif.o_dead !== 1'b1) $display("FAIL esc_hi_dead: got %b exp 1", pif.o_dead); else passed++;
        total++; if (pif.o_escaped !== 1'b1) $display("FAIL esc_hi_esc: got %b exp 1", pif.o_escaped); else passed++;
        total++; if (pif.o_layer !== 3'd5) $display("FAIL esc_hi_layer: got %h exp 5", pif.o_layer); else passed++;
        total++; if (pif.o_uz !== 32'h3000_0000) $display("FAIL esc_hi_uz: got %h exp 30000000", pif.o_uz); else passed++;
    endtask

    task automatic test_bypass;
        launch(1'b0, 1'b0, 3'd4, 32'h0123_4567, 32'h0765_4321, 32'h1234_5678, 32'h3000_0000, 32'd0,
               B2, H2, 64'd0, 32'h0777_0000, 32'h0888_0000);
        total++; if (pif.o_uz !== 32'h1234_5678) $display("FAIL byp_uz: got %h exp 12345678", pif.o_uz); else passed++;
        total++; if (pif.o_ux !== 32'h0123_4567) $display("FAIL byp_ux: got %h exp 01234567", pif.o_ux); else passed++;
        total++; if (pif.o_layer !== 3'd4) $display("FAIL byp_layer: got %h exp 4", pif.o_layer); else passed++;
        total++; if ({pif.o_dead, pif.o_reflected, pif.o_escaped} !== 3'b000) $display("FAIL byp_flags: got %b exp 000", {pif.o_dead, pif.o_reflected, pif.o_escaped}); else passed++;
        launch(1'b1, 1'b1, 3'd1, 32'h0123_4567, 32'h0765_4321, 32'hC000_0000, 32'h3000_0000, 32'hFFFF_FFFF,
               B2, H2, 64'd0, 32'h0777_0000, 32'h0888_0000);
        total++; if ({pif.o_dead, pif.o_reflected, pif.o_escaped} !== 3'b100) $display("FAIL dead_flags: got %b exp 100", {pif.o_dead, pif.o_reflected, pif.o_escaped}); else passed++;
        total++; if (pif.o_uz !== 32'hC000_0000) $display("FAIL dead_uz: got %h exp c0000000", pif.o_uz); else passed++;
    endtask

    task automatic test_back_to_back;
        int          sent = 0;
        int          got  = 0;
        logic        en_cur;
        logic [31:0] tag;
        exp_q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            en_cur = !(cyc >= 3 && cyc < 6);
            enable = en_cur;
            if (sent < 6)
                drive(1'b1, 1'b0, 3'd2, 32'h0100_0000, 32'h0200_0000, A, A, 32'd0, A2, A2, 64'd0, 32'h1000_0000 + sent, 32'h0666_0000);
            else
                pif.i_valid = 1'b0;
            step;
            if (en_cur && sent < 6) begin
                exp_q.push_back(32'h1000_0000 + sent);
                sent++;
            end
            if (en_cur && pif.o_valid) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got %h exp none", pif.o_ux);
                end else begin
                    tag = exp_q.pop_front();
                    if (pif.o_ux !== tag) $display("FAIL b2b_order: got %h exp %h", pif.o_ux, tag); else passed++;
                end
            end
        end
        enable = 1'b1;
        total++; if (got != 6 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d exp 6 (left %0d)", got, exp_q.size()); else passed++;
    endtask

    task automatic test_flush;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 3'd2, 32'h0100_0000, 32'h0200_0000, A, A, 32'd0, A2, A2, 64'd0, 32'h2000_0000 + k, 32'h0666_0000);
            step;
        end
        pif.i_valid = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++; if (pif.o_valid !== 1'b0) $display("FAIL flush_%0d: got %b exp 0", k, pif.o_valid); else passed++;
            step;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running exp finished");
        $fatal(1);
    end

    initial begin
        pif.i_valid = 1'b0;
        test_reset;
        test_matched;
        test_fresnel;
        test_tir;
        test_escape;
        test_bypass;
        test_back_to_back;
        test_flush;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/photon_reflector.md
# photon_reflector

Boundary-interaction stage of the photon-migration pipeline, consuming the registered boundary internals (uz², new uz, sin²θ₂, uz2²) and the transmitted-direction candidates. For each photon that hit a layer boundary it decides between total internal reflection, Fresnel reflection and transmission, then emits the updated direction, layer and dead/escaped status. It is a fixed-latency, enable-stalled 4-stage pipeline with one photon accepted per enabled clock.

## Interface
- NUM_LAYERS, 5, number of tissue layers; valid layers are 1..NUM_LAYERS.
- LAYER_W, 3, width of layer index.
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global pipeline advance; low holds every stage register.
- i_valid  in  1  photon present this cycle.
- i_hit  in  1  photon reached a boundary.
- i_dead  in  1  photon already terminated.
- i_layer  in  LAYER_W  current layer.
- i_ux, i_uy, i_uz  in  32  signed Q1.31 direction cosines.
- i_rand  in  32  unsigned Q0.32 uniform random.
- i_uz_2  in  64  uz², unsigned Q2.62.
- i_uz2  in  32  |uz| in next layer, unsigned Q1.31.
- i_sa2_2  in  64  sin²θ₂, Q2.62.
- i_uz2_2  in  64  uz2², Q2.62.
- i_ux_transmitted, i_uy_transmitted  in  32  Q1.31 transmitted ux/uy.
- o_valid, o_dead, o_reflected, o_escaped  out  1 each.
- o_layer  out  LAYER_W.
- o_ux, o_uy, o_uz  out  32  Q1.31.

## Operation
- Bypass: i_hit=0 or i_dead=1 → direction, layer, dead passed unchanged; o_reflected=0, o_escaped=0.
- TIR: i_sa2_2 ≥ 64'h4000_0000_0000_0000 or i_uz2=0 → reflect.
- Otherwise, with p = |uz|·uz2 (Q2.62, 64-bit unsigned), N = uz_2 + uz2_2 − 2p, D = uz_2 + uz2_2 + 2p (both 66-bit unsigned): reflect iff (i_rand·D) >> 32 < N. Full-width products; no truncation before compare.
- Reflect: o_ux=ux, o_uy=uy, o_uz=−uz (0x8000_0000 → 0x7FFF_FFFF), layer unchanged, o_reflected=1.
- Transmit: o_ux/o_uy = transmitted values, o_uz = uz<0 ? −uz2 : uz2, o_layer = uz<0 ? layer−1 : layer+1.
- Escape: transmit with (layer=1, uz<0) or (layer=NUM_LAYERS, uz≥0) → o_dead=1, o_escaped=1, o_layer unchanged, direction as transmit.
- Stage 1: register inputs, compute p. Stage 2: N, D, TIR flag. Stage 3: i_rand·D. Stage 4: compare, select, register outputs.

## Timing
- Latency: exactly 4 enabled clocks from i_valid sample to o_valid; throughput 1 photon per enabled clock.
- enable=0: all stage registers, including valid bits and outputs, hold; no drop, no duplication.
- o_valid may be 1 for a photon that was valid at input; bubbles (i_valid=0) propagate as o_valid=0.
- Reset (overrides enable): next edge all stage valids cleared; in-flight photons discarded. Output reset values: o_valid 0, o_dead 0, o_reflected 0, o_escaped 0, o_layer 0, o_ux 0, o_uy 0, o_uz 32'h7FFF_FFFF.
- No backpressure: downstream must accept each o_valid on the enabled clock it appears.

## Structure
- photon_pkg: Q-format constants ONE_Q2_62 = 64'h4000_0000_0000_0000, ONE_Q1_31 = 32'h7FFF_FFFF, LAYER_W, photon direction struct.
- One sub-module, fresnel_compare: stages 1–3 arithmetic plus compare bit, enable-stalled, 3-cycle latency; top handles bypass/select and sideband delay.

## Test plan
- Reset: reset high one cycle, i_valid=1 throughout → all outputs at reset values, o_valid=0 until 4 enabled clocks after release.
- Matched index: uz=uz2=0x7FFF_FFFF, uz_2=uz2_2=0x3FFF_FFFF_0000_0001, i_rand=0, layer 2 → transmit, o_layer=3, o_uz=0x7FFF_FFFF, o_reflected=0.
- Fresnel split (R=1/9): uz=0x7FFF_FFFF, uz2=0x4000_0000, exact squares; i_rand=0x1C00_0000 → reflect, o_uz=0x8000_0001; i_rand=0x1D00_0000 → transmit, o_uz=0x4000_0000.
- TIR: i_sa2_2=0x4000_0000_0000_0001, uz=0xC000_0000, ux=0x1000_0000 → o_uz=0x4000_0000, o_ux=0x1000_0000, layer unchanged, o_reflected=1.
- Escape: layer 1, uz=0xC000_0000, transmit forced (i_rand=0xFFFF_FFFF) → o_dead=1, o_escaped=1, o_layer=1; layer NUM_LAYERS with uz>0 likewise.
- Stall and flush: 6 back-to-back photons, enable low 3 cycles mid-stream → outputs in order, none lost; reset with 3 in flight → no o_valid for those photons.
